pe_array_sequencer: RTL
=======================

PE_ARRAY_SEQUENCER -- requirements
Module: pe_array_sequencer

Interface
REQ-001 SHALL have parameter inputBits, default 8, operand/weight width.
REQ-002 SHALL have parameter ROWS, default 4, weights shifted into the PE e-chain per job.
REQ-003 SHALL have parameter CNT_W, default 16, width of k_len and beat counters.
REQ-004 SHALL have parameter MAC_LAT, default 3, cycles from last operand to valid PE result.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports start (input, 1, job request) and k_len (input, CNT_W, operand beats per job, sampled on accepted start).
REQ-008 SHALL have port abort  input  1  synchronous job cancel.
REQ-009 SHALL have ports w_valid, w_data[inputBits] (input) and w_ready (output, 1): weight stream handshake.
REQ-010 SHALL have ports act_valid (input, 1) and act_ready (output, 1): operand stream handshake.
REQ-011 SHALL have ports e_enable (output, 1) and e_data (output, inputBits): PE weight-load controls.
REQ-012 SHALL have ports op_en (output, 1: gate a..d operands, zero when low), acc_clear (output, 1), out_valid (output, 1), busy (output, 1), done (output, 1).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-014 IDLE: start=1 and k_len!=0 -> LOAD, latch k_len; start=1 and k_len==0 -> DONE; otherwise stay.
REQ-015 start while not IDLE SHALL be ignored.
REQ-016 LOAD: w_ready=1; each w_valid&&w_ready beat SHALL increment load_cnt; ROWS-th beat -> STREAM.
REQ-017 e_enable and e_data SHALL be registered: asserted/loaded the cycle after each weight beat, e_enable low otherwise, e_data holding last value.
REQ-018 STREAM: act_ready=1; each act_valid&&act_ready beat SHALL increment k_cnt; beat with k_cnt==k_len-1 -> DRAIN.
REQ-019 op_en SHALL be registered: high the cycle after each operand beat, low otherwise (stall bubbles give zero operands).
REQ-020 acc_clear SHALL be high concurrently with op_en for the first operand beat of a job only.
REQ-021 DRAIN: SHALL count MAC_LAT cycles after the last op_en; on final count out_valid=1 for one cycle and -> DONE.
REQ-022 DONE: done=1 for exactly one cycle, then -> IDLE; k_len==0 jobs SHALL produce done without out_valid, e_enable or op_en.
REQ-023 busy SHALL be high in LOAD, STREAM, DRAIN, DONE; low in IDLE.
REQ-024 w_ready SHALL be low outside LOAD; act_ready low outside STREAM.
REQ-025 abort (any non-IDLE state) SHALL force IDLE next cycle, clear counters and registered outputs, suppress done/out_valid; abort has priority over every transition.
REQ-026 k_cnt SHALL not wrap: k_len=2^CNT_W-1 SHALL complete with exactly that many op_en pulses.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, all counters 0, e_data 0, and all outputs 0.
REQ-028 rst low mid-job SHALL discard the job; no done after release.

Structure
REQ-029 State enum and default MAC_LAT SHALL live in shared package pe_ctrl_pkg.
REQ-030 Counters SHALL use one reusable sub-module beat_counter (enable, clear, terminal-count flag) instantiated three times (load, k, drain).

Verification
REQ-031 ROWS=4, MAC_LAT=3, k_len=5, continuous valids: 4 e_enable pulses, 5 op_en pulses, acc_clear on first only, out_valid 3 cycles after last op_en, done next cycle.
REQ-032 act_valid toggled 1,0,1,0... with k_len=3: op_en follows with 1-cycle lag, zero-gaps, out_valid timing relative to last op_en unchanged.
REQ-033 start with k_len=0: done 1 cycle after IDLE exit; no e_enable/op_en/out_valid.
REQ-034 abort during STREAM after 2 of 5 beats: busy low next cycle, no out_valid/done; new job then completes normally.
REQ-035 rst asserted in LOAD after 2 weights: all outputs 0 immediately; after release, start restarts a full 4-weight load.
REQ-036 start pulsed during DRAIN: ignored; exactly one done.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared types and defaults for the PE array control path.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStream,
    StDrain,
    StDone
  } seq_state_e;

  localparam int unsigned MacLatDefault = 3;

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Job, weight/operand handshakes and PE-control outputs of the sequencer.
interface pe_array_sequencer_if #(
  parameter int unsigned inputBits = 8,
  parameter int unsigned CNT_W     = 16
) ();

  logic                 start;
  logic [CNT_W-1:0]     k_len;
  logic                 abort;
  logic                 w_valid;
  logic [inputBits-1:0] w_data;
  logic                 w_ready;
  logic                 act_valid;
  logic                 act_ready;
  logic                 e_enable;
  logic [inputBits-1:0] e_data;
  logic                 op_en;
  logic                 acc_clear;
  logic                 out_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output start, k_len, abort, w_valid, w_data, act_valid,
    input  w_ready, act_ready, e_enable, e_data, op_en, acc_clear, out_valid, busy, done
  );

  modport slave (
    input  start, k_len, abort, w_valid, w_data, act_valid,
    output w_ready, act_ready, e_enable, e_data, op_en, acc_clear, out_valid, busy, done
  );

endinterface

// File: rtl/beat_counter.sv
// Up-counter with synchronous clear (priority over enable) and terminal-count flag.
module beat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [Width-1:0] term,
  output logic [Width-1:0] count,
  output logic             tc
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;
  assign tc    = (count_q == term);

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences one PE job: weight load into the e-chain, operand streaming, MAC drain, done.
module pe_array_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned inputBits = 8,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAC_LAT   = MacLatDefault
) (
  input logic                  clk,
  input logic                  rst,
  pe_array_sequencer_if.slave  bus
);

  seq_state_e state_q, state_d;

  logic [CNT_W-1:0]     k_len_q;
  logic                 e_enable_q;
  logic [inputBits-1:0] e_data_q;
  logic                 op_en_q;
  logic                 acc_clear_q;

  logic             w_beat, a_beat, cnt_clr;
  logic             load_tc, k_tc, drain_tc;
  logic [CNT_W-1:0] load_count, k_count, drain_count;
  logic             unused_cnt;

  assign w_beat  = bus.w_valid & bus.w_ready;
  assign a_beat  = bus.act_valid & bus.act_ready;
  // Counters sit at zero whenever no job is in flight.
  assign cnt_clr = (state_q == StIdle) | bus.abort;

  beat_counter #(.Width(CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_beat),
    .clr   (cnt_clr),
    .term  (CNT_W'(ROWS - 1)),
    .count (load_count),
    .tc    (load_tc)
  );

  // Terminal value k_len-1 never requires the counter to pass all-ones, so no wrap.
  beat_counter #(.Width(CNT_W)) u_k_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (a_beat),
    .clr   (cnt_clr),
    .term  (k_len_q - CNT_W'(1)),
    .count (k_count),
    .tc    (k_tc)
  );

  beat_counter #(.Width(CNT_W)) u_drain_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == StDrain),
    .clr   (cnt_clr),
    .term  (CNT_W'(MAC_LAT)),
    .count (drain_count),
    .tc    (drain_tc)
  );

  assign unused_cnt = ^{load_count, drain_count};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.start) state_d = (bus.k_len != '0) ? StLoad : StDone;
      StLoad:   if (w_beat && load_tc) state_d = StStream;
      StStream: if (a_beat && k_tc) state_d = StDrain;
      StDrain:  if (drain_tc) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (bus.abort) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_len_q     <= '0;
      e_enable_q  <= 1'b0;
      e_data_q    <= '0;
      op_en_q     <= 1'b0;
      acc_clear_q <= 1'b0;
    end else if (bus.abort) begin
      k_len_q     <= '0;
      e_enable_q  <= 1'b0;
      e_data_q    <= '0;
      op_en_q     <= 1'b0;
      acc_clear_q <= 1'b0;
    end else begin
      if (state_q == StIdle && bus.start && bus.k_len != '0) k_len_q <= bus.k_len;
      e_enable_q  <= w_beat;
      if (w_beat) e_data_q <= bus.w_data;
      op_en_q     <= a_beat;
      acc_clear_q <= a_beat && (k_count == '0);
    end
  end

  assign bus.w_ready   = (state_q == StLoad);
  assign bus.act_ready = (state_q == StStream);
  assign bus.e_enable  = e_enable_q;
  assign bus.e_data    = e_data_q;
  assign bus.op_en     = op_en_q;
  assign bus.acc_clear = acc_clear_q;
  assign bus.busy      = (state_q != StIdle);
  // An abort in the final DRAIN/DONE cycle still cancels the job's completion pulses.
  assign bus.out_valid = (state_q == StDrain) && drain_tc && !bus.abort;
  assign bus.done      = (state_q == StDone) && !bus.abort;

endmodule
